// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller: edge-detects the divider scan clock,
// lights one digit per slot for DWELL_TICKS ticks with a one-tick blank guard, latches data per frame.
module seg_scan_ctrl #(
  parameter int DWELL_TICKS = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        scan_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_TICKS - 1);

  typedef enum logic {GAP, SHOW} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;
  logic [15:0]   dig_q, dig_d;
  logic [3:0]    dpm_q, dpm_d;
  logic [3:0]    en_q, en_d;
  logic          blz_q, blz_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic          tick;
  logic          load;
  logic [15:0]   dig_s;
  logic [3:0]    dpm_s;
  logic [3:0]    en_s;
  logic          blz_s;
  logic [3:0]    nib;
  logic          upper_zero;
  logic [3:0]    lit_an;
  logic [6:0]    lit_seg;
  logic          lit_dp;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick = scan_clk & ~prev_q;
    load = (idx_q == 2'd0);

    // Slot 0 lights in the same edge that latches, so it must see the live inputs.
    dig_s = load ? digits   : dig_q;
    dpm_s = load ? dp_mask  : dpm_q;
    en_s  = load ? digit_en : en_q;
    blz_s = load ? blank_lz : blz_q;
    nib   = dig_s[{idx_q, 2'b00} +: 4];

    case (idx_q)
      2'd1:    upper_zero = (dig_s[15:4]  == 12'h000);
      2'd2:    upper_zero = (dig_s[15:8]  == 8'h00);
      2'd3:    upper_zero = (dig_s[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase

    lit_an  = 4'b1111;
    lit_seg = 7'b1111111;
    lit_dp  = 1'b1;
    if (en_s[idx_q]) begin
      if (blz_s && upper_zero) begin
        lit_dp = ~dpm_s[idx_q];
        if (dpm_s[idx_q]) lit_an = ~(4'b0001 << idx_q);
      end else begin
        lit_an  = ~(4'b0001 << idx_q);
        lit_seg = hex7(nib);
        lit_dp  = ~dpm_s[idx_q];
      end
    end

    prev_d  = scan_clk;
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    dpm_d   = dpm_q;
    en_d    = en_q;
    blz_d   = blz_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    fd_d    = 1'b0;

    if (tick) begin
      case (state_q)
        GAP: begin
          if (load) begin
            dig_d = digits;
            dpm_d = dp_mask;
            en_d  = digit_en;
            blz_d = blank_lz;
          end
          state_d = SHOW;
          cnt_d   = '0;
          an_d    = lit_an;
          seg_d   = lit_seg;
          dp_d    = lit_dp;
        end
        default: begin
          if (cnt_q == CNT_MAX) begin
            state_d = GAP;
            an_d    = 4'b1111;
            seg_d   = 7'b1111111;
            dp_d    = 1'b1;
            idx_d   = idx_q + 2'd1;
            fd_d    = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= GAP;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      prev_q  <= 1'b1;
      dig_q   <= 16'h0000;
      dpm_q   <= 4'h0;
      en_q    <= 4'h0;
      blz_q   <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      dig_q   <= dig_d;
      dpm_q   <= dpm_d;
      en_q    <= en_d;
      blz_q   <= blz_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: reset, scan order, leading-zero blanking,
// tear-free latch, digit disable with wrap, and mid-frame clear.
module tb_seg_scan_ctrl;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        clr;
  logic        scan_clk;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  logic fd_at_tick;
  logic fd_after;

  localparam logic [6:0] BLANK = 7'b1111111;

  seg_scan_ctrl #(.DWELL_TICKS(D)) dut (
    .clk        (clk),
    .clr        (clr),
    .scan_clk   (scan_clk),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One scan_clk rising edge: high for one clk, then low for one clk.
  task automatic tick();
    scan_clk = 1'b1;
    step();
    fd_at_tick = frame_done;
    scan_clk = 1'b0;
    step();
    fd_after = frame_done;
  endtask

  task automatic show_slot(input string tag, input logic [3:0] ean, input logic [6:0] eseg, input logic edp);
    tick();
    check({tag, " an"}, 32'(an), 32'(ean));
    check({tag, " seg"}, 32'(seg), 32'(eseg));
    check({tag, " dp"}, 32'(dp), 32'(edp));
  endtask

  task automatic end_slot(input string tag, input logic [3:0] ean, input logic last);
    for (int i = 0; i < D - 1; i++) begin
      tick();
      check({tag, " hold an"}, 32'(an), 32'(ean));
    end
    tick();
    check({tag, " gap an"}, 32'(an), 32'hF);
    check({tag, " gap seg"}, 32'(seg), 32'(BLANK));
    check({tag, " gap dp"}, 32'(dp), 32'd1);
    check({tag, " fd pulse"}, 32'(fd_at_tick), 32'(last));
    check({tag, " fd one clk"}, 32'(fd_after), 32'd0);
  endtask

  task automatic run_slot(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                          input logic edp, input logic last);
    show_slot(tag, ean, eseg, edp);
    end_slot(tag, ean, last);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; scan_clk = 1'b0;
    digits = 16'h1234; dp_mask = 4'b0010; digit_en = 4'b1111; blank_lz = 1'b0;

    // Reset hold with scan_clk toggling
    for (int i = 0; i < 6; i++) begin
      scan_clk = ~scan_clk;
      step();
      check("rst an", 32'(an), 32'hF);
      check("rst seg", 32'(seg), 32'(BLANK));
      check("rst dp", 32'(dp), 32'd1);
      check("rst fd", 32'(frame_done), 32'd0);
    end
    scan_clk = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("release no tick", 32'(an), 32'hF);
    end
    scan_clk = 1'b0;
    step();

    // Basic scan 1234, dp on digit 1
    run_slot("basic s0", 4'b1110, 7'b0011001, 1'b1, 1'b0);
    run_slot("basic s1", 4'b1101, 7'b0110000, 1'b0, 1'b0);
    run_slot("basic s2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
    run_slot("basic s3", 4'b0111, 7'b1111001, 1'b1, 1'b1);

    // Leading zero blanking
    digits = 16'h0050; blank_lz = 1'b1; dp_mask = 4'b0100;
    run_slot("lz s0", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    run_slot("lz s1", 4'b1101, 7'b0010010, 1'b1, 1'b0);
    run_slot("lz s2", 4'b1011, BLANK, 1'b0, 1'b0);
    run_slot("lz s3", 4'b1111, BLANK, 1'b1, 1'b1);

    // Tear-free latch
    digits = 16'hAAAA; blank_lz = 1'b0; dp_mask = 4'b0000;
    run_slot("tear s0", 4'b1110, 7'b0001000, 1'b1, 1'b0);
    run_slot("tear s1", 4'b1101, 7'b0001000, 1'b1, 1'b0);
    show_slot("tear s2", 4'b1011, 7'b0001000, 1'b1);
    digits = 16'h5555;
    end_slot("tear s2", 4'b1011, 1'b0);
    run_slot("tear s3", 4'b0111, 7'b0001000, 1'b1, 1'b1);
    run_slot("new s0", 4'b1110, 7'b0010010, 1'b1, 1'b0);
    run_slot("new s1", 4'b1101, 7'b0010010, 1'b1, 1'b0);
    run_slot("new s2", 4'b1011, 7'b0010010, 1'b1, 1'b0);
    run_slot("new s3", 4'b0111, 7'b0010010, 1'b1, 1'b1);

    // Digit disable over two frames
    digit_en = 4'b0101;
    for (int f = 0; f < 2; f++) begin
      run_slot("dis s0", 4'b1110, 7'b0010010, 1'b1, 1'b0);
      run_slot("dis s1", 4'b1111, BLANK, 1'b1, 1'b0);
      run_slot("dis s2", 4'b1011, 7'b0010010, 1'b1, 1'b0);
      run_slot("dis s3", 4'b1111, BLANK, 1'b1, 1'b1);
    end

    // Mid-frame clear during slot 2
    digit_en = 4'b1111; digits = 16'h1234;
    run_slot("mid s0", 4'b1110, 7'b0011001, 1'b1, 1'b0);
    run_slot("mid s1", 4'b1101, 7'b0110000, 1'b1, 1'b0);
    show_slot("mid s2", 4'b1011, 7'b0100100, 1'b1);
    digits = 16'h0009;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr an", 32'(an), 32'hF);
    check("clr seg", 32'(seg), 32'(BLANK));
    check("clr dp", 32'(dp), 32'd1);
    step();
    run_slot("after clr s0", 4'b1110, 7'b0010000, 1'b1, 1'b0);
    run_slot("after clr s1", 4'b1101, 7'b1000000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
